fifo_drain_control: RTL and testbench

FIFO_DRAIN_CONTROL -- requirements
Module: fifo_drain_control

---
 rtl/cnn_pkg.sv | 15 +
 rtl/fifo_row_mask.sv | 25 ++
 rtl/fifo_drain_control.sv | 124 ++++++++++++
 tb/tb_fifo_drain_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN control package.
// Holds the control-FSM state encoding used by both the FIFO fill and the
// FIFO drain controllers, so the two blocks always agree on the values
// reported on their state ports.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FILL = 3'd1,
    DRAIN     = 3'd2,
    FLUSH     = 3'd3,
    DONE      = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/fifo_row_mask.sv
// Skew-mask generator for the systolic-array row FIFOs.
// Row i is read while i <= t < i + len, which staggers the rows by one
// cycle each so data enters the array diagonally.
// Ports:
//   t    - skew counter (dim_data_size+1 bits)
//   len  - captured drain length (reads per row)
//   mask - one bit per row, 1 when that row is in its read window
module fifo_row_mask #(
  parameter int array_size    = 9,
  parameter int dim_data_size = 8
) (
  input  logic [dim_data_size:0]   t,
  input  logic [dim_data_size-1:0] len,
  output logic [array_size-1:0]    mask
);

  localparam int W = dim_data_size + 1;

  // The upper bound i + len needs the extra counter bit: with
  // array_size <= 2**dim_data_size it never exceeds 2**W - 2.
  for (genvar i = 0; i < array_size; i++) begin : g_row
    assign mask[i] = (t >= W'(i)) && (t < ({1'b0, len} + W'(i)));
  end

endmodule

// File: rtl/fifo_drain_control.sv
// FIFO drain controller.
// Waits for the fill controller to finish, then reads each row FIFO
// drain_length times with a one-cycle skew per row. Any masked row that
// is empty stalls the whole pattern for that cycle, so every row still
// gets exactly drain_length strobes. valid_out follows the read strobes
// by one clock to line up with the FIFO read data.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   enable           - level request to run one drain pass
//   fill_done        - fill controller completion level
//   drain_length     - reads per row FIFO, captured at pass start
//   fifo_empty       - per-row empty flags
//   read_enable_out  - per-row read strobes
//   valid_out        - per-row data valid (read strobes delayed by 1)
//   state            - current FSM state encoding
//   completed        - high while the pass is finished (DONE)
module fifo_drain_control
  import cnn_pkg::*;
#(
  parameter int array_size    = 9,
  parameter int dim_data_size = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     fill_done,
  input  logic [dim_data_size-1:0] drain_length,
  input  logic [array_size-1:0]    fifo_empty,
  output logic [array_size-1:0]    read_enable_out,
  output logic [array_size-1:0]    valid_out,
  output logic [2:0]               state,
  output logic                     completed
);

  localparam int W = dim_data_size + 1;

  if (array_size > (1 << dim_data_size)) begin : g_size_check
    $error("fifo_drain_control: array_size must not exceed 2**dim_data_size");
  end

  ctrl_state_t               cur_state;
  ctrl_state_t               nxt_state;
  logic [W-1:0]              t;
  logic [W-1:0]              t_inc;
  logic [W-1:0]              t_last;
  logic [dim_data_size-1:0]  len;
  logic [array_size-1:0]     mask;
  logic                      stall;
  logic                      start_drain;

  fifo_row_mask #(
    .array_size    (array_size),
    .dim_data_size (dim_data_size)
  ) u_row_mask (
    .t    (t),
    .len  (len),
    .mask (mask)
  );

  assign state       = cur_state;
  assign t_inc       = t + W'(1);
  // The last strobe cycle is t = len + array_size - 2; leaving DRAIN when
  // the incremented count would hit len + array_size - 1.
  assign t_last      = {1'b0, len} + W'(array_size - 1);
  assign start_drain = (cur_state == WAIT_FILL) && fill_done && (drain_length != '0);

  always_comb begin
    nxt_state       = cur_state;
    read_enable_out = '0;
    completed       = 1'b0;
    stall           = 1'b0;
    case (cur_state)
      IDLE: begin
        if (enable) nxt_state = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (fill_done) nxt_state = (drain_length != '0) ? DRAIN : DONE;
      end
      DRAIN: begin
        stall = |(mask & fifo_empty);
        if (!stall) begin
          read_enable_out = mask;
          if (t_inc == t_last) nxt_state = FLUSH;
        end
      end
      FLUSH: begin
        nxt_state = DONE;
      end
      DONE: begin
        completed = 1'b1;
        if (!enable) nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Counter, length capture and one-cycle valid delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t         <= '0;
      len       <= '0;
      valid_out <= '0;
    end else begin
      valid_out <= read_enable_out;
      if (start_drain) begin
        len <= drain_length;
        t   <= '0;
      end else if (cur_state == DRAIN && !stall) begin
        t <= t_inc;
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_control.sv
// Bench for fifo_drain_control: directed passes with a scoreboard of
// expected read masks, one entry per non-stalled drain cycle.
module tb_fifo_drain_control;
  import cnn_pkg::*;

  localparam int N = 9;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fill_done;
  logic [D-1:0]  drain_length;
  logic [N-1:0]  fifo_empty;
  logic [N-1:0]  read_enable_out;
  logic [N-1:0]  valid_out;
  logic [2:0]    state;
  logic          completed;

  int            checks = 0;
  int            failures = 0;
  logic [N-1:0]  sb[$];
  ctrl_state_t   exp_state;
  logic [N-1:0]  exp_valid;
  int            pops;
  int            row_cnt[N];
  int            drain_cycles;
  int            strobes;

  always #5 clk = ~clk;

  fifo_drain_control #(
    .array_size    (N),
    .dim_data_size (D)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .fill_done       (fill_done),
    .drain_length    (drain_length),
    .fifo_empty      (fifo_empty),
    .read_enable_out (read_enable_out),
    .valid_out       (valid_out),
    .state           (state),
    .completed       (completed)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input int l);
    logic [N-1:0] m;
    for (int k = 0; k < l + N - 1; k++) begin
      m = '0;
      for (int i = 0; i < N; i++)
        if (i <= k && k < i + l) m[i] = 1'b1;
      sb.push_back(m);
    end
  endtask

  // Compare at the falling edge, then advance the reference model across
  // the rising edge using the inputs held over it.
  task automatic tick();
    logic [N-1:0] exp_re;
    logic         stl;
    @(negedge clk);
    exp_re = '0;
    stl    = 1'b0;
    if (exp_state == DRAIN && sb.size() != 0) begin
      stl = |(sb[0] & fifo_empty);
      if (!stl) exp_re = sb[0];
    end
    chk("state", 32'(state), 32'(exp_state));
    chk("read_enable_out", 32'(read_enable_out), 32'(exp_re));
    chk("valid_out", 32'(valid_out), 32'(exp_valid));
    chk("completed", 32'(completed), 32'(exp_state == DONE));
    if (state == 3'(DRAIN)) drain_cycles++;
    for (int i = 0; i < N; i++) row_cnt[i] += int'(read_enable_out[i]);
    strobes += $countones(read_enable_out);
    @(posedge clk);
    exp_valid = exp_re;
    case (exp_state)
      IDLE:      if (enable) exp_state = WAIT_FILL;
      WAIT_FILL: if (fill_done) begin
                   if (drain_length != '0) begin
                     push_pass(int'(drain_length));
                     pops = 0;
                     exp_state = DRAIN;
                   end else begin
                     exp_state = DONE;
                   end
                 end
      DRAIN:     if (!stl) begin
                   void'(sb.pop_front());
                   pops++;
                   if (sb.size() == 0) exp_state = FLUSH;
                 end
      FLUSH:     exp_state = DONE;
      DONE:      if (!enable) exp_state = IDLE;
      default:   exp_state = IDLE;
    endcase
    #1;
  endtask

  task automatic clear_stats();
    drain_cycles = 0;
    strobes = 0;
    for (int i = 0; i < N; i++) row_cnt[i] = 0;
  endtask

  task automatic run_pass(input int l, input bit do_stall, input bit change_len,
                          input int exp_drain, input int exp_strobes);
    int stall_left;
    int n;
    clear_stats();
    stall_left   = do_stall ? 2 : 0;
    drain_length = D'(l);
    fifo_empty   = '0;
    fill_done    = 1'b0;
    enable       = 1'b1;
    tick();
    tick();
    fill_done = 1'b1;
    n = 0;
    while (exp_state != DONE && n < 200) begin
      fifo_empty = '0;
      if (stall_left > 0 && exp_state == DRAIN && pops == 4) begin
        fifo_empty[3] = 1'b1;
        stall_left--;
      end
      if (change_len && exp_state == DRAIN && pops == 3) drain_length = D'(2);
      tick();
      n++;
    end
    fifo_empty = '0;
    chk("pass_in_bound", 32'(n < 200), 32'd1);
    tick();
    enable    = 1'b0;
    fill_done = 1'b0;
    tick();
    tick();
    chk("drain_cycles", 32'(drain_cycles), 32'(exp_drain));
    chk("total_strobes", 32'(strobes), 32'(exp_strobes));
    for (int i = 0; i < N; i++) chk("row_strobes", 32'(row_cnt[i]), 32'(l));
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    enable       = 1'b0;
    fill_done    = 1'b0;
    drain_length = '0;
    fifo_empty   = '0;
    exp_state    = IDLE;
    exp_valid    = '0;
    pops         = 0;
    clear_stats();
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_read_enable", 32'(read_enable_out), 32'd0);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_completed", 32'(completed), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // Nominal pass, L=5.
    run_pass(5, 1'b0, 1'b0, 13, 45);
    // Row 3 empty for two cycles at t=4.
    run_pass(5, 1'b1, 1'b0, 15, 45);
    // Zero length goes straight to DONE.
    run_pass(0, 1'b0, 1'b0, 0, 0);

    // Reset in the middle of a drain.
    clear_stats();
    drain_length = D'(5);
    enable       = 1'b1;
    fill_done    = 1'b0;
    tick();
    tick();
    fill_done = 1'b1;
    n = 0;
    while (!(exp_state == DRAIN && pops == 6) && n < 100) begin
      tick();
      n++;
    end
    chk("reach_t6", 32'(n < 100), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_read_enable", 32'(read_enable_out), 32'd0);
    chk("midreset_valid", 32'(valid_out), 32'd0);
    chk("midreset_state", 32'(state), 32'd0);
    enable    = 1'b0;
    fill_done = 1'b0;
    sb.delete();
    exp_state = IDLE;
    exp_valid = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    run_pass(3, 1'b0, 1'b0, 11, 27);

    // drain_length changes mid-pass; the captured value must hold.
    run_pass(5, 1'b0, 1'b1, 13, 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
